wb_sram32_ctrl: RTL and testbench

//   Wishbone classic slave to asynchronous 32-bit SRAM controller. Converts CPU/bus

---
 rtl/wb_sram32_ctrl_if.sv | 33 +++
 rtl/wb_sram32_ctrl.sv | 141 ++++++++++++++
 tb/tb_wb_sram32_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram32_ctrl_if.sv
// Bus bundle between a Wishbone classic master and the SRAM controller,
// including the SRAM pad-side signals the controller drives.
interface wb_sram32_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W+1:0] wb_adr_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic [31:0]       sram_dat_i;
    logic [31:0]       sram_dat_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [3:0]        sram_bsel_o;
    logic              sram_cs_o;
    logic              sram_oe_o;
    logic              sram_we_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, sram_dat_i,
        output wb_dat_o, wb_ack_o, sram_dat_o, sram_addr_o, sram_bsel_o,
               sram_cs_o, sram_oe_o, sram_we_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, sram_dat_i,
        input  wb_dat_o, wb_ack_o, sram_dat_o, sram_addr_o, sram_bsel_o,
               sram_cs_o, sram_oe_o, sram_we_o
    );
endinterface

// File: rtl/wb_sram32_ctrl.sv
// Wishbone classic slave driving an asynchronous 32-bit SRAM (two 16-bit parts).
// Every output is a flop; the next-state logic also computes next strobe values
// so the registered strobes line up with the registered state.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no access, waiting for cyc&stb
// READ     | cs+oe asserted RD_WAIT cycles, data captured on last edge
// RACK     | strobes low, read ack
// WSETUP   | cs asserted, addr/bsel/data settle before we
// WRITE    | we asserted WR_WAIT cycles
// WHOLD    | we low, cs held, write ack
// ACK      | zero-byte-select request, ack without touching the SRAM
// TURN     | bus turnaround, last cycle may accept the next request
module wb_sram32_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    parameter int TURN    = 1
) (
    input  logic                   clk_50mhz,
    input  logic                   reset_n,
    wb_sram32_ctrl_if.slave        bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_RACK, ST_WSETUP, ST_WRITE, ST_WHOLD, ST_ACK, ST_TURN
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       live, live_nxt;
    logic       req, accept, capture;
    logic       cs_nxt, oe_nxt, we_nxt, ack_nxt;
    logic [31:0] lane_mask;

    assign req = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
    assign lane_mask = {{8{bus.sram_bsel_o[3]}}, {8{bus.sram_bsel_o[2]}},
                        {8{bus.sram_bsel_o[1]}}, {8{bus.sram_bsel_o[0]}}};

    // Next state, counter, ack qualifier and next strobe values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: accept = req;
            ST_READ: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RACK;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RACK, ST_WHOLD, ST_ACK: begin
                if (TURN == 0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_TURN;
                    cnt_nxt   = 4'(TURN - 1);
                end
            end
            ST_WSETUP: begin
                state_nxt = ST_WRITE;
                cnt_nxt   = 4'(WR_WAIT - 1);
            end
            ST_WRITE: begin
                if (cnt == 4'd0) state_nxt = ST_WHOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_TURN: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                    accept    = req;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (accept) begin
            if (bus.wb_sel_i == 4'd0) begin
                state_nxt = ST_ACK;
            end else if (bus.wb_we_i) begin
                state_nxt = ST_WSETUP;
            end else begin
                state_nxt = ST_READ;
                cnt_nxt   = 4'(RD_WAIT - 1);
            end
        end

        // A master that drops cyc at any point forfeits the ack; the SRAM
        // sequence still runs to completion so no write pulse is cut short.
        live_nxt = accept | (live & bus.wb_cyc_i);

        cs_nxt  = (state_nxt == ST_READ) || (state_nxt == ST_WSETUP) ||
                  (state_nxt == ST_WRITE) || (state_nxt == ST_WHOLD);
        oe_nxt  = (state_nxt == ST_READ);
        we_nxt  = (state_nxt == ST_WRITE);
        ack_nxt = live_nxt && ((state_nxt == ST_RACK) || (state_nxt == ST_WHOLD) ||
                               (state_nxt == ST_ACK));
    end

    // State register plus registered strobes, latched request and read data.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            cnt             <= 4'd0;
            live            <= 1'b0;
            bus.sram_cs_o   <= 1'b0;
            bus.sram_oe_o   <= 1'b0;
            bus.sram_we_o   <= 1'b0;
            bus.wb_ack_o    <= 1'b0;
            bus.sram_addr_o <= '0;
            bus.sram_bsel_o <= 4'd0;
            bus.sram_dat_o  <= 32'd0;
            bus.wb_dat_o    <= 32'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            live          <= live_nxt;
            bus.sram_cs_o <= cs_nxt;
            bus.sram_oe_o <= oe_nxt;
            bus.sram_we_o <= we_nxt;
            bus.wb_ack_o  <= ack_nxt;
            if (accept) begin
                bus.sram_addr_o <= bus.wb_adr_i[ADDR_W+1:2];
                bus.sram_bsel_o <= bus.wb_sel_i;
                bus.sram_dat_o  <= bus.wb_dat_i;
                bus.wb_dat_o    <= 32'd0;
            end
            if (capture) begin
                bus.wb_dat_o <= bus.sram_dat_i & lane_mask;
            end
        end
    end

endmodule

// File: tb/tb_wb_sram32_ctrl.sv
// Directed bench for wb_sram32_ctrl with a behavioural 2x16 SRAM model.
module tb_wb_sram32_ctrl;
    localparam int ADDR_W = 18;

    logic clk_50mhz = 1'b0;
    logic reset_n   = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    wb_sram32_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    wb_sram32_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(1), .WR_WAIT(1), .TURN(1)) dut (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // SRAM model: 256 words, byte-lane writes while cs&we, async read.
    logic [31:0] mem [256];
    logic [7:0]  midx;
    assign midx = bus.sram_addr_o[7:0];
    assign bus.sram_dat_i = (bus.sram_cs_o && bus.sram_oe_o) ? mem[midx] : 32'h0;

    always @(posedge clk_50mhz) begin
        if (bus.sram_cs_o && bus.sram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_bsel_o[b]) mem[midx][8*b +: 8] <= bus.sram_dat_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic start(input logic we, input logic [19:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
    endtask

    task automatic stop();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    int ack_cnt;
    int last_ack;
    logic overlap;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_sel_i = 4'd0;
        bus.wb_dat_i = 32'd0;

        // Reset values
        #25;
        chk("rst_cs",   {31'd0, bus.sram_cs_o}, 32'd0);
        chk("rst_ack",  {31'd0, bus.wb_ack_o},  32'd0);
        chk("rst_dat",  bus.wb_dat_o,           32'd0);
        chk("rst_addr", {14'd0, bus.sram_addr_o}, 32'd0);
        @(negedge clk_50mhz);
        reset_n = 1'b1;
        tick();

        // 1. full write then read
        start(1'b1, 20'h0048C, 4'hF, 32'hDEADBEEF);
        tick();
        chk("w1_c1_cs",   {31'd0, bus.sram_cs_o}, 32'd1);
        chk("w1_c1_we",   {31'd0, bus.sram_we_o}, 32'd0);
        chk("w1_addr",    {14'd0, bus.sram_addr_o}, 32'h123);
        chk("w1_c1_ack",  {31'd0, bus.wb_ack_o},  32'd0);
        tick();
        chk("w1_c2_we",   {31'd0, bus.sram_we_o}, 32'd1);
        chk("w1_c2_oe",   {31'd0, bus.sram_oe_o}, 32'd0);
        tick();
        chk("w1_c3_cs",   {31'd0, bus.sram_cs_o}, 32'd1);
        chk("w1_c3_we",   {31'd0, bus.sram_we_o}, 32'd0);
        chk("w1_c3_ack",  {31'd0, bus.wb_ack_o},  32'd1);
        stop();
        tick();
        chk("w1_turn_cs", {31'd0, bus.sram_cs_o}, 32'd0);
        chk("w1_turn_ack",{31'd0, bus.wb_ack_o},  32'd0);
        chk("w1_mem",     mem[8'h23],             32'hDEADBEEF);
        start(1'b0, 20'h0048C, 4'hF, 32'h0);
        tick();
        chk("r1_c1_oe",   {31'd0, bus.sram_oe_o}, 32'd1);
        chk("r1_c1_ack",  {31'd0, bus.wb_ack_o},  32'd0);
        tick();
        chk("r1_c2_ack",  {31'd0, bus.wb_ack_o},  32'd1);
        chk("r1_c2_oe",   {31'd0, bus.sram_oe_o}, 32'd0);
        chk("r1_dat",     bus.wb_dat_o,           32'hDEADBEEF);
        stop();
        tick();

        // 2. single-lane write and readback
        start(1'b1, 20'h0048C, 4'b0100, 32'h00AA0000);
        tick();
        chk("w2_bsel", {28'd0, bus.sram_bsel_o}, 32'h4);
        tick();
        tick();
        chk("w2_ack",  {31'd0, bus.wb_ack_o}, 32'd1);
        stop();
        tick();
        start(1'b0, 20'h0048C, 4'hF, 32'h0);
        tick();
        tick();
        chk("r2_ack",  {31'd0, bus.wb_ack_o}, 32'd1);
        chk("r2_dat",  bus.wb_dat_o,          32'hDEAABEEF);
        stop();
        tick();

        // 3. cyc dropped during WRITE
        start(1'b1, 20'h00010, 4'hF, 32'h12345678);
        tick();
        tick();
        stop();
        chk("w3_we_high", {31'd0, bus.sram_we_o}, 32'd1);
        tick();
        chk("w3_no_ack",  {31'd0, bus.wb_ack_o},  32'd0);
        chk("w3_we_low",  {31'd0, bus.sram_we_o}, 32'd0);
        chk("w3_cs_hold", {31'd0, bus.sram_cs_o}, 32'd1);
        tick();
        chk("w3_turn_ack",{31'd0, bus.wb_ack_o},  32'd0);
        start(1'b0, 20'h00010, 4'hF, 32'h0);
        tick();
        chk("r3_oe",  {31'd0, bus.sram_oe_o}, 32'd1);
        tick();
        chk("r3_ack", {31'd0, bus.wb_ack_o},  32'd1);
        chk("r3_dat", bus.wb_dat_o,           32'h12345678);
        stop();
        tick();

        // 4. zero byte selects
        start(1'b0, 20'h0048C, 4'h0, 32'h0);
        tick();
        chk("s0_ack", {31'd0, bus.wb_ack_o},  32'd1);
        chk("s0_cs",  {31'd0, bus.sram_cs_o}, 32'd0);
        chk("s0_oe",  {31'd0, bus.sram_oe_o}, 32'd0);
        chk("s0_dat", bus.wb_dat_o,           32'd0);
        stop();
        tick();
        chk("s0_ack_once", {31'd0, bus.wb_ack_o}, 32'd0);
        tick();

        // 5. reset during READ
        start(1'b0, 20'h0048C, 4'hF, 32'h0);
        tick();
        chk("rr_cs_before", {31'd0, bus.sram_cs_o}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rr_cs",  {31'd0, bus.sram_cs_o}, 32'd0);
        chk("rr_oe",  {31'd0, bus.sram_oe_o}, 32'd0);
        chk("rr_ack", {31'd0, bus.wb_ack_o},  32'd0);
        @(posedge clk_50mhz);
        #4;
        reset_n = 1'b1;
        tick();
        chk("rr2_oe",  {31'd0, bus.sram_oe_o}, 32'd1);
        tick();
        chk("rr2_ack", {31'd0, bus.wb_ack_o},  32'd1);
        chk("rr2_dat", bus.wb_dat_o,           32'hDEAABEEF);
        stop();
        tick();
        tick();

        // 6. four reads with stb held high
        mem[0] = 32'h11110000;
        mem[1] = 32'h22221111;
        mem[2] = 32'h33332222;
        mem[3] = 32'h44443333;
        ack_cnt  = 0;
        last_ack = 0;
        overlap  = 1'b0;
        start(1'b0, 20'h00000, 4'hF, 32'h0);
        for (int cyc = 1; cyc <= 40 && ack_cnt < 4; cyc++) begin
            tick();
            if (bus.sram_oe_o && bus.sram_we_o) overlap = 1'b1;
            if (bus.wb_ack_o) begin
                case (ack_cnt)
                    0: chk("b2b_dat0", bus.wb_dat_o, 32'h11110000);
                    1: chk("b2b_dat1", bus.wb_dat_o, 32'h22221111);
                    2: chk("b2b_dat2", bus.wb_dat_o, 32'h33332222);
                    default: chk("b2b_dat3", bus.wb_dat_o, 32'h44443333);
                endcase
                if (ack_cnt == 0) chk("b2b_first", cyc, 32'd2);
                else              chk("b2b_gap", cyc - last_ack, 32'd3);
                last_ack = cyc;
                ack_cnt++;
                bus.wb_adr_i = 20'(ack_cnt * 4);
                if (ack_cnt == 4) stop();
            end
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (bus.sram_oe_o && bus.sram_we_o) overlap = 1'b1;
            if (bus.wb_ack_o) ack_cnt++;
        end
        chk("b2b_acks",    ack_cnt,          32'd4);
        chk("b2b_overlap", {31'd0, overlap}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
